// File: rtl/sign_extend_pipe.sv
// sign_extend_pipe: runtime-length sign/zero extender feeding a valid/ready output FIFO
module sign_extend_pipe #(
   parameter int IN_W  = 40,
   parameter int OUT_W = 48,
   parameter int LEN_W = 6,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  X,
   input  logic [LEN_W-1:0] Len,
   input  logic             Signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] Y,
   output logic             LenErr,
   output logic [LEN_W-1:0] Count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   if (IN_W < 2 || OUT_W < IN_W || (1 << LEN_W) <= IN_W || DEPTH < 1 || (1 << LEN_W) <= DEPTH) begin : g_bad_params
      $error("sign_extend_pipe: illegal parameter combination");
   end
   logic [OUT_W:0]   mem_q [DEPTH];
   logic [OUT_W:0]   mem_d [DEPTH];
   logic [OUT_W:0]   head_q, head_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;
   logic [LEN_W-1:0] l;
   logic [OUT_W-1:0] x_w, mask, y_entry;
   logic             len_err, sgn, acc, pop;
   assign in_ready  = ready_q;
   assign out_valid = count_q != '0;
   assign Y         = head_q[OUT_W-1:0];
   assign LenErr    = head_q[OUT_W];
   assign Count     = count_q;
   always_comb begin
      len_err = Len == '0 || Len > LEN_W'(IN_W);
      l       = len_err ? LEN_W'(IN_W) : Len;
      x_w     = OUT_W'(X);
      mask    = ~({OUT_W{1'b1}} << l);
      sgn     = Signed & x_w[l - 1'b1];
      y_entry = (x_w & mask) | ({OUT_W{sgn}} & ~mask);
      acc     = in_valid & ready_q;
      pop     = out_valid & out_ready;
      mem_d   = mem_q;
      if (acc) mem_d[wr_q] = {len_err, y_entry};
      wr_d    = acc ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
      count_d = count_q + LEN_W'(acc) - LEN_W'(pop);
      ready_d = count_d < LEN_W'(DEPTH);
      // the head register keeps its old value once the FIFO drains
      head_d  = count_d != '0 ? mem_d[rd_d] : head_q;
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         head_q  <= head_d;
         ready_q <= ready_d;
      end
   end
endmodule

// File: tb/tb_sign_extend_pipe.sv
// tb_sign_extend_pipe: directed literal checks plus randomized traffic against a queue model
module tb_sign_extend_pipe;
   localparam int IN_W  = 40;
   localparam int OUT_W = 48;
   localparam int LEN_W = 6;
   localparam int DEPTH = 2;
   logic             clk = 1'b0;
   logic             rst_n, in_valid, in_ready, Signed, out_valid, out_ready, LenErr;
   logic [IN_W-1:0]  X;
   logic [LEN_W-1:0] Len, Count;
   logic [OUT_W-1:0] Y;
   int               n_chk = 0;
   int               n_fail = 0;
   logic [OUT_W:0]   q[$];
   logic [OUT_W:0]   last_head = '0;
   bit               m_rdy = 1'b0;
   bit               started = 1'b0;

   sign_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Len(Len),
      .Signed(Signed), .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .LenErr(LenErr),
      .Count(Count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [OUT_W:0] ref_ext(input logic [IN_W-1:0] x, input int len, input bit s);
      logic [OUT_W-1:0] y;
      bit ok = len >= 1 && len <= IN_W;
      int fl = ok ? len : IN_W;
      for (int i = 0; i < OUT_W; i++)
         if (i < fl) y[i] = x[i];
         else        y[i] = s & x[fl-1];
      return {!ok, y};
   endfunction

   always @(posedge clk) begin
      bit acc, pop;
      started = 1'b1;
      if (!rst_n) begin
         q.delete();
         m_rdy = 1'b0;
         last_head = '0;
      end else begin
         acc = in_valid && m_rdy && q.size() < DEPTH;
         pop = q.size() != 0 && out_ready;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(ref_ext(X, int'(Len), Signed));
         m_rdy = 1'b1;
         if (q.size() != 0) last_head = q[0];
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("model Count", 64'(Count), 64'(q.size()));
         chk("model in_ready", 64'(in_ready), 64'(m_rdy && q.size() < DEPTH));
         chk("model Y", 64'(Y), 64'(last_head[OUT_W-1:0]));
         chk("model LenErr", 64'(LenErr), 64'(last_head[OUT_W]));
      end
   end

   task automatic xfer(input logic [IN_W-1:0] x, input int len, input bit s,
                       input logic [OUT_W-1:0] ey, input bit ee);
      @(posedge clk); #1;
      X = x; Len = LEN_W'(len); Signed = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lit out_valid", 64'(out_valid), 64'd1);
      chk("lit Y", 64'(Y), 64'(ey));
      chk("lit LenErr", 64'(LenErr), 64'(ee));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OUT_W-1:0] ya, yb, yc;
      ya = 48'h0012_3456_789A;
      yb = 48'hFFFF_FFFF_FFF0;
      yc = 48'hFFFF_FFFF_FFFF;
      rst_n = 1'b0; in_valid = 1'b1; X = 40'hA5_5A5A_A5A5; Len = 6'd40; Signed = 1'b1; out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst Y", 64'(Y), 64'd0);
         chk("rst out_valid", 64'(out_valid), 64'd0);
         chk("rst Count", 64'(Count), 64'd0);
         chk("rst in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("release in_ready", 64'(in_ready), 64'd1);
      chk("release out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      xfer(40'h80_0000_0001, 40, 1'b1, 48'hFF80_0000_0001, 1'b0);
      xfer(40'h80_0000_0001, 40, 1'b0, 48'h0080_0000_0001, 1'b0);
      xfer(40'hFF_FFFF_FF80, 8, 1'b1, 48'hFFFF_FFFF_FF80, 1'b0);
      xfer(40'hFF_FFFF_FF80, 8, 1'b0, 48'h0000_0000_0080, 1'b0);
      xfer(40'h00_0000_007F, 8, 1'b1, 48'h0000_0000_007F, 1'b0);
      xfer(40'h80_0000_0000, 0, 1'b1, 48'hFF80_0000_0000, 1'b1);
      xfer(40'h80_0000_0000, 63, 1'b1, 48'hFF80_0000_0000, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      X = 40'h12_3456_789A; Len = 6'd40; Signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      X = 40'h00_0000_00F0; Len = 6'd8; Signed = 1'b1;
      @(posedge clk); #1;
      X = 40'h00_0000_0003; Len = 6'd2; Signed = 1'b1;
      @(negedge clk);
      chk("full Count", 64'(Count), 64'd2);
      chk("full in_ready", 64'(in_ready), 64'd0);
      chk("full Y=A", 64'(Y), 64'(ya));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("held Y=A", 64'(Y), 64'(ya));
      chk("held Count", 64'(Count), 64'd2);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pop Y=B", 64'(Y), 64'(yb));
      chk("pop Count", 64'(Count), 64'd1);
      chk("pop in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("C accepted Count", 64'(Count), 64'd2);
      chk("C accepted Y=B", 64'(Y), 64'(yb));
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("drain Y=C", 64'(Y), 64'(yc));
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         X = {$urandom, $urandom} & {IN_W{1'b1}}; Len = LEN_W'($urandom_range(1, IN_W));
         Signed = 1'($urandom); in_valid = 1'b1;
         @(negedge clk);
         if (i > 0) chk("stream Count", 64'(Count), 64'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      X = 40'h55_0000_00AA; Len = 6'd16; Signed = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("prereset Count", 64'(Count), 64'd2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset Count", 64'(Count), 64'd0);
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         X = {$urandom, $urandom} & {IN_W{1'b1}};
         Len = ($urandom_range(0, 4) != 0) ? LEN_W'($urandom_range(1, IN_W)) : LEN_W'($urandom);
         Signed = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + 2) @(posedge clk);
      @(negedge clk);
      chk("final drain", 64'(Count), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
